// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbitration of two writeback requesters onto one register-file write port, with read forwarding and a conflict counter
module rf_write_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          rf_reg_write,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_write_data,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2,
  input  logic          cnt_clr,
  output logic [CW-1:0] conflict_cnt
);
  logic          r_ptr;
  logic          r_we;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic          w_ptr_nxt;
  logic          w_xfer;
  logic [AW-1:0] w_rd;
  logic [DW-1:0] w_data;
  logic          w_both;
  // Pointer low favours A, high favours B; the loser of a contested grant gets it next time
  always_comb begin
    w_both    = a_valid && b_valid;
    a_ready   = a_valid && (!b_valid || !r_ptr);
    b_ready   = b_valid && (!a_valid || r_ptr);
    w_xfer    = a_ready || b_ready;
    w_ptr_nxt = w_xfer ? a_ready : r_ptr;
    w_rd      = a_ready ? a_rd : b_rd;
    w_data    = a_ready ? a_data : b_data;
  end
  // Priority pointer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= 1'b0;
    else        r_ptr <= w_ptr_nxt;
  end
  // Register the granted write; r0 writes are consumed but never committed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_rd   <= w_rd;
        r_data <= w_data;
      end
    end
  end
  // Saturating count of cycles where both requesters compete; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (cnt_clr)                    r_cnt <= '0;
    else if (w_both && r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
  end
  // Bypass the in-flight write to the read ports; r0 always reads zero
  always_comb begin
    fwd_data1 = (rs == '0) ? '0 : (r_we && r_rd == rs) ? r_data : rf_data1;
    fwd_data2 = (rt == '0) ? '0 : (r_we && r_rd == rt) ? r_data : rf_data2;
  end
  assign rf_reg_write  = r_we;
  assign rf_rd         = r_rd;
  assign rf_write_data = r_data;
  assign conflict_cnt  = r_cnt;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of arbitration, write stage, forwarding, reset and counter saturation
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, cnt_clr = 1'b0;
  logic [4:0]  a_rd = '0, b_rd = '0, rs = '0, rt = '0;
  logic [31:0] a_data = '0, b_data = '0, rf_data1 = '0, rf_data2 = '0;
  logic        a_ready, b_ready, rf_reg_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data, fwd_data1, fwd_data2;
  logic [15:0] conflict_cnt;
  int checks = 0;
  int errors = 0;

  rf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .rs(rs), .rt(rt), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, conflict_cnt} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%0b rd=%0d data=%0h cnt=%0d, want all zero", rf_reg_write, rf_rd, rf_write_data, conflict_cnt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    a_valid = 1; a_rd = 5'd1; a_data = 32'd100;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_a_ready: got a=%0b b=%0b, want a=1 b=0", a_ready, b_ready);
    end
    tick();
    a_valid = 0;
    checks++;
    if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, 5'd1, 32'd100}) begin
      errors++;
      $display("FAIL single_a_write: got we=%0b rd=%0d data=%0d, want we=1 rd=1 data=100", rf_reg_write, rf_rd, rf_write_data);
    end
    rs = 5'd1; rf_data1 = 32'd7;
    #1;
    checks++;
    if (fwd_data1 !== 32'd100) begin
      errors++;
      $display("FAIL single_a_inflight_fwd: got %0d, want 100", fwd_data1);
    end
    tick();
    checks++;
    if (rf_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL single_a_we_drop: got %0b, want 0", rf_reg_write);
    end
    checks++;
    if (fwd_data1 !== 32'd7) begin
      errors++;
      $display("FAIL single_a_no_fwd: got %0d, want 7", fwd_data1);
    end
    rf_data1 = 32'd100;
    #1;
    checks++;
    if (fwd_data1 !== 32'd100) begin
      errors++;
      $display("FAIL single_a_later_read: got %0d, want 100", fwd_data1);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rd;
    do_reset();
    a_valid = 1; a_rd = 5'd2; a_data = 32'd200;
    b_valid = 1; b_rd = 5'd3; b_data = 32'd300;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got a=%0b b=%0b, want %s", i, a_ready, b_ready, (i % 2 == 0) ? "A" : "B");
      end
      tick();
      exp_rd = (i % 2 == 0) ? 5'd2 : 5'd3;
      checks++;
      if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, exp_rd, (i % 2 == 0) ? 32'd200 : 32'd300}) begin
        errors++;
        $display("FAIL rr_write[%0d]: got we=%0b rd=%0d data=%0d, want we=1 rd=%0d", i, rf_reg_write, rf_rd, rf_write_data, exp_rd);
      end
    end
    a_valid = 0; b_valid = 0;
    checks++;
    if (conflict_cnt !== 16'd4) begin
      errors++;
      $display("FAIL rr_conflict_cnt: got %0d, want 4", conflict_cnt);
    end
    tick();
  endtask

  task automatic test_forwarding();
    b_valid = 1; b_rd = 5'd5; b_data = 32'hDEADBEEF;
    tick();
    b_valid = 0;
    rs = 5'd5; rt = 5'd6; rf_data1 = 32'h0; rf_data2 = 32'h11;
    #1;
    checks++;
    if ({rf_reg_write, rf_rd} !== {1'b1, 5'd5} || fwd_data1 !== 32'hDEADBEEF || fwd_data2 !== 32'h11) begin
      errors++;
      $display("FAIL fwd_basic: got we=%0b rd=%0d f1=%0h f2=%0h, want we=1 rd=5 f1=deadbeef f2=11", rf_reg_write, rf_rd, fwd_data1, fwd_data2);
    end
    rt = 5'd5;
    #1;
    checks++;
    if (fwd_data2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_port2: got %0h, want deadbeef", fwd_data2);
    end
    tick();
  endtask

  task automatic test_r0_write();
    a_valid = 1; a_rd = 5'd7; a_data = 32'd70;
    tick();
    a_valid = 0;
    b_valid = 1; b_rd = 5'd0; b_data = 32'h55;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL r0_ready: got a=%0b b=%0b, want a=0 b=1", a_ready, b_ready);
    end
    tick();
    b_valid = 0;
    rs = 5'd0; rf_data1 = 32'h99;
    #1;
    checks++;
    if (rf_reg_write !== 1'b0 || fwd_data1 !== 32'h0) begin
      errors++;
      $display("FAIL r0_no_write: got we=%0b f1=%0h, want we=0 f1=0", rf_reg_write, fwd_data1);
    end
    a_valid = 1; b_valid = 1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL r0_ptr_to_a: got a=%0b b=%0b, want a=1 b=0", a_ready, b_ready);
    end
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_async_reset();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    b_valid = 1; b_rd = 5'd8; b_data = 32'd8;
    tick();
    b_valid = 0;
    a_valid = 1; a_rd = 5'd9; a_data = 32'd9;
    b_valid = 1;
    tick();
    a_valid = 0; b_valid = 0;
    checks++;
    if (rf_reg_write !== 1'b1 || rf_rd !== 5'd9 || conflict_cnt !== 16'd1) begin
      errors++;
      $display("FAIL areset_pre: got we=%0b rd=%0d cnt=%0d, want we=1 rd=9 cnt=1", rf_reg_write, rf_rd, conflict_cnt);
    end
    #1;
    rst_n = 0;
    #1;
    checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, conflict_cnt} !== 54'd0) begin
      errors++;
      $display("FAIL areset_clear: got we=%0b rd=%0d data=%0d cnt=%0d, want all zero", rf_reg_write, rf_rd, rf_write_data, conflict_cnt);
    end
    rst_n = 1;
    a_valid = 1; b_valid = 1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL areset_ptr: got a=%0b b=%0b, want a=1 b=0", a_ready, b_ready);
    end
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_saturation();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    a_valid = 1; a_rd = 5'd10; a_data = 32'd1;
    b_valid = 1; b_rd = 5'd11; b_data = 32'd2;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (conflict_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: got %0h, want fffe", conflict_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (conflict_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_hold[%0d]: got %0h, want ffff", i, conflict_cnt);
      end
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0; a_valid = 0; b_valid = 0;
    checks++;
    if (conflict_cnt !== 16'h0) begin
      errors++;
      $display("FAIL sat_clear: got %0h, want 0", conflict_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_forwarding();
    test_r0_write();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
